// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants and FSM encoding used by the
// alignment (denormalization), normalization and rounding stages.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int GRS_W   = 3;
    localparam int ALIGN_W = MANT_W + GRS_W;
    localparam int SHAMT_W = $clog2(ALIGN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sticky_shr.sv
// Combinational right shift with sticky collection: every bit shifted out is
// ORed into the LSB of the result so rounding information is never lost.
module sticky_shr
    import fp_pkg::*;
#(
    parameter int W  = ALIGN_W,
    parameter int SW = SHAMT_W
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] sh,
    output logic [W-1:0]  dout
);

    logic [W-1:0] shifted_s;
    logic [W-1:0] mask_s;
    logic         lost_s;

    // Shift, then fold the discarded low bits into the sticky position.
    always_comb begin
        shifted_s = din >> sh;
        mask_s    = ~({W{1'b1}} << sh);
        lost_s    = |(din & mask_s);
        dout      = {shifted_s[W-1:1], shifted_s[0] | lost_s};
    end

endmodule

// File: rtl/denormalization.sv
// Operand alignment ahead of the FP adder: orders two operands by magnitude and
// right-shifts the smaller mantissa STEP bits per cycle, producing G/R/S bits.
module denormalization #(
    parameter int STEP   = 4,
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              signA,
    input  logic              signB,
    input  logic [EXP_W-1:0]  expA,
    input  logic [EXP_W-1:0]  expB,
    input  logic [FRAC_W-1:0] fracA,
    input  logic [FRAC_W-1:0] fracB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              swap,
    output logic              signBig,
    output logic              signSmall,
    output logic [EXP_W-1:0]  expOut,
    output logic [FRAC_W:0]   fracBig,
    output logic [FRAC_W+3:0] fracSmall
);

    import fp_pkg::*;

    localparam int MW = FRAC_W + 1;
    localparam int AW = MW + 3;
    localparam int SW = $clog2(AW + 1);
    localparam logic [SW-1:0]    STEP_C = SW'(STEP);
    localparam logic [EXP_W-1:0] AW_E   = EXP_W'(AW);

    state_e           state_r;
    logic [AW-1:0]    v_r;
    logic [SW-1:0]    rem_r;

    logic [EXP_W-1:0] eff_a_s, eff_b_s, eff_big_s, eff_small_s, diff_s;
    logic [MW-1:0]    mant_a_s, mant_b_s, mant_big_s, mant_small_s;
    logic             b_bigger_s, sign_big_s, sign_small_s;
    logic [SW-1:0]    d_s, step_s;
    logic [AW-1:0]    v_next_s;

    // Effective operands: denormals use exponent 1 and a cleared hidden bit.
    always_comb begin
        mant_a_s   = {(expA != {EXP_W{1'b0}}), fracA};
        mant_b_s   = {(expB != {EXP_W{1'b0}}), fracB};
        eff_a_s    = (expA == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : expA;
        eff_b_s    = (expB == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : expB;
        b_bigger_s = ({expB, fracB} > {expA, fracA});
        if (b_bigger_s) begin
            eff_big_s    = eff_b_s;
            eff_small_s  = eff_a_s;
            mant_big_s   = mant_b_s;
            mant_small_s = mant_a_s;
            sign_big_s   = signB;
            sign_small_s = signA;
        end else begin
            eff_big_s    = eff_a_s;
            eff_small_s  = eff_b_s;
            mant_big_s   = mant_a_s;
            mant_small_s = mant_b_s;
            sign_big_s   = signA;
            sign_small_s = signB;
        end
        diff_s = eff_big_s - eff_small_s;
        if (diff_s > AW_E) begin
            d_s = SW'(AW);
        end else begin
            d_s = diff_s[SW-1:0];
        end
    end

    // Per-cycle shift amount is the smaller of what remains and STEP.
    always_comb begin
        if (rem_r < STEP_C) begin
            step_s = rem_r;
        end else begin
            step_s = STEP_C;
        end
    end

    sticky_shr #(.W(AW), .SW(SW)) u_sticky_shr (
        .din  (v_r),
        .sh   (step_s),
        .dout (v_next_s)
    );

    // Control FSM and registered result; the result holds while DONE waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            v_r       <= {AW{1'b0}};
            rem_r     <= {SW{1'b0}};
            swap      <= 1'b0;
            signBig   <= 1'b0;
            signSmall <= 1'b0;
            expOut    <= {EXP_W{1'b0}};
            fracBig   <= {MW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        swap      <= b_bigger_s;
                        signBig   <= sign_big_s;
                        signSmall <= sign_small_s;
                        expOut    <= eff_big_s;
                        fracBig   <= mant_big_s;
                        v_r       <= {mant_small_s, 3'b000};
                        rem_r     <= d_s;
                        state_r   <= (d_s == {SW{1'b0}}) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    v_r   <= v_next_s;
                    rem_r <= rem_r - step_s;
                    if (rem_r == step_s) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign fracSmall = v_r;
    assign out_valid = (state_r == DONE);
    assign in_ready  = rst_n & (state_r == IDLE);

endmodule

// File: tb/tb_denormalization.sv
// Scoreboard bench for denormalization: a driver pushes expected results from
// an arithmetic reference model, a monitor pops and compares on handshake.
module tb_denormalization;

    localparam int STEP = 4;

    typedef struct {
        logic        sw;
        logic        sb;
        logic        ss;
        logic [7:0]  ex;
        logic [23:0] fb;
        logic [26:0] fs;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        signA, signB, swap, signBig, signSmall;
    logic [7:0]  expA, expB, expOut;
    logic [22:0] fracA, fracB;
    logic [23:0] fracBig;
    logic [26:0] fracSmall;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    logic prev_valid = 1'b0;

    denormalization #(.STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .signA(signA), .signB(signB), .expA(expA), .expB(expB),
        .fracA(fracA), .fracB(fracB), .out_valid(out_valid), .out_ready(out_ready),
        .swap(swap), .signBig(signBig), .signSmall(signSmall), .expOut(expOut),
        .fracBig(fracBig), .fracSmall(fracSmall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: align the whole small mantissa in one step with integer math.
    function automatic exp_t model(input logic sa, input logic [7:0] ea, input logic [22:0] fa,
                                   input logic sb, input logic [7:0] eb, input logic [22:0] fb);
        exp_t   r;
        longint ma, mb, ms, v;
        int     xa, xb, d;
        ma   = (ea != 0) ? (64'd8388608 + fa) : longint'(fa);
        mb   = (eb != 0) ? (64'd8388608 + fb) : longint'(fb);
        xa   = (ea == 0) ? 1 : int'(ea);
        xb   = (eb == 0) ? 1 : int'(eb);
        r.sw = (longint'(eb) * 64'd8388608 + fb) > (longint'(ea) * 64'd8388608 + fa);
        if (r.sw) begin
            r.sb = sb; r.ss = sa; r.ex = eb == 0 ? 8'd1 : eb; r.fb = 24'(mb); ms = ma; d = xb - xa;
        end else begin
            r.sb = sa; r.ss = sb; r.ex = ea == 0 ? 8'd1 : ea; r.fb = 24'(ma); ms = mb; d = xa - xb;
        end
        if (d > 27) d = 27;
        v    = ms * 8;
        r.fs = 27'((v >> d) | ((v % (64'd1 << d)) != 0 ? 1 : 0));
        r.lat = (d + STEP - 1) / STEP;
        r.acc = 0;
        return r;
    endfunction

    task automatic send(input logic sa, input logic [7:0] ea, input logic [22:0] fa,
                        input logic sb, input logic [7:0] eb, input logic [22:0] fb);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        signA = sa; expA = ea; fracA = fa;
        signB = sb; expB = eb; fracB = fb;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = model(sa, ea, fa, sb, eb, fb);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: compare presented result every valid cycle, pop on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!prev_valid) chk("latency", 32'(cyc), 32'(q[0].acc + q[0].lat));
                    chk("swap", 32'(swap), 32'(q[0].sw));
                    chk("signBig", 32'(signBig), 32'(q[0].sb));
                    chk("signSmall", 32'(signSmall), 32'(q[0].ss));
                    chk("expOut", 32'(expOut), 32'(q[0].ex));
                    chk("fracBig", 32'(fracBig), 32'(q[0].fb));
                    chk("fracSmall", 32'(fracSmall), 32'(q[0].fs));
                    chk("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int n;
        logic [7:0] ea, eb;
        rst_n = 1'b0; in_valid = 1'b0;
        signA = 1'b0; signB = 1'b0; expA = 8'd0; expB = 8'd0; fracA = 23'd0; fracB = 23'd0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_fracSmall", 32'(fracSmall), 32'd0);
        chk("reset_expOut", 32'(expOut), 32'd0);
        #21 rst_n = 1'b1;

        send(1'b0, 8'd127, 23'd0, 1'b1, 8'd127, 23'd0);
        send(1'b0, 8'd127, 23'd0, 1'b0, 8'd125, 23'd0);
        send(1'b1, 8'd120, 23'h000001, 1'b0, 8'd127, 23'd0);
        send(1'b0, 8'd200, 23'd0, 1'b1, 8'd100, 23'h7FFFFF);
        send(1'b0, 8'd1, 23'd0, 1'b0, 8'd0, 23'h400000);
        send(1'b0, 8'd0, 23'd0, 1'b1, 8'd0, 23'd0);

        // Backpressure: result must hold while out_ready stays low.
        rdy_mode = 2;
        send(1'b0, 8'd120, 23'h000001, 1'b1, 8'd127, 23'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        rdy_mode = 0;

        // Asynchronous reset in the middle of a long shift.
        send(1'b0, 8'd200, 23'd0, 1'b1, 8'd100, 23'h7FFFFF);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_fracSmall", 32'(fracSmall), 32'd0);
        q.delete();
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        send(1'b1, 8'd130, 23'h123456, 1'b0, 8'd127, 23'h654321);

        // Random operands, mostly with nearby exponents, random consumer stalls.
        rdy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            ea = 8'($urandom_range(0, 254));
            case ($urandom_range(0, 3))
                0:       eb = 8'($urandom_range(0, 254));
                1:       eb = 8'd0;
                default: eb = (ea > 8'd234) ? ea - 8'($urandom_range(0, 20)) : ea + 8'($urandom_range(0, 20));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                send(1'($urandom), ea, 23'($urandom), 1'($urandom), eb, 23'($urandom));
            end else begin
                send(1'($urandom), eb, 23'($urandom), 1'($urandom), ea, 23'($urandom));
            end
        end
        rdy_mode = 0;

        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_scoreboard", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
